// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Cleans up raw push-button levels before they reach the pixel-generation
// stage. Each channel passes through a 2-FF synchronizer and then a
// counter-based debounce FSM. The FSM drives three registered outputs: a
// debounced level, a one-cycle press pulse and a one-cycle release pulse.
//
// Optional feature (macro BTN_REPEAT_EN): when this macro is defined, a held
// button produces auto-repeat press pulses. The first repeat comes
// REPEAT_DELAY cycles after the press pulse. Later repeats come every
// REPEAT_PERIOD cycles while the channel stays in PRESSED. When the macro is
// undefined, no repeat logic is built.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   btn_raw     in   [NUM_BTN] asynchronous raw levels, 1 = pressed
//   btn_level   out  [NUM_BTN] debounced level (registered)
//   btn_press   out  [NUM_BTN] one-cycle pulse per accepted press / repeat
//   btn_release out  [NUM_BTN] one-cycle pulse per accepted release
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int NUM_BTN       = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  logic [NUM_BTN-1:0] sync1_q, sync1_d;
  logic [NUM_BTN-1:0] sync2_q, sync2_d;
  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] btn_level_q, btn_level_d;
  logic [NUM_BTN-1:0] btn_press_q, btn_press_d;
  logic [NUM_BTN-1:0] btn_release_q, btn_release_d;
  logic [NUM_BTN-1:0] rep_fire;

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0]   rep_cnt_q [NUM_BTN];
  logic [REP_W-1:0]   rep_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_armed_q, rep_armed_d;

  // Fire when the channel stays in PRESSED and the counter reaches its
  // current threshold. The threshold is the initial delay until the first
  // repeat fires; after that, it is the repeat period.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (state_q[i] == PRESSED && sync2_q[i]) begin
        if (rep_armed_q[i])
          rep_fire[i] = (rep_cnt_q[i] == REP_W'(REPEAT_PERIOD - 1));
        else
          rep_fire[i] = (rep_cnt_q[i] == REP_W'(REPEAT_DELAY - 1));
      end
    end
  end

  // The repeat counter only advances while a channel remains in PRESSED.
  // Entering PRESSED (from a press or a bounce back from WAIT_RELEASE)
  // starts the initial delay from zero again.
  always_comb begin
    rep_armed_d = rep_armed_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      rep_cnt_d[i] = '0;
      if (state_q[i] == PRESSED && state_d[i] == PRESSED) begin
        if (rep_fire[i]) begin
          rep_armed_d[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end else begin
        rep_armed_d[i] = 1'b0;
      end
    end
  end

  // Repeat state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_armed_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_armed_q <= rep_armed_d;
      for (int i = 0; i < NUM_BTN; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  assign rep_fire = '0;
`endif

  // State register, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      btn_level_q   <= '0;
      btn_press_q   <= '0;
      btn_release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next state: the FSM only ever looks at the second synchronizer stage.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = WAIT_PRESS;
            cnt_d[i]   = '0;
          end
        end
        WAIT_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            state_d[i] = PRESSED;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = WAIT_RELEASE;
            cnt_d[i]   = '0;
          end
        end
        WAIT_RELEASE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: pulses are raised only on the edge where a debounce completes
  // (or a repeat fires), so they clear by themselves one cycle later.
  always_comb begin
    btn_level_d   = btn_level_q;
    btn_press_d   = '0;
    btn_release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      case (state_q[i])
        WAIT_PRESS: begin
          if (sync2_q[i] && cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            btn_level_d[i] = 1'b1;
            btn_press_d[i] = 1'b1;
          end
        end
        PRESSED: begin
          btn_press_d[i] = rep_fire[i];
        end
        WAIT_RELEASE: begin
          if (!sync2_q[i] && cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
            btn_level_d[i]   = 1'b0;
            btn_release_d[i] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Testbench for button_conditioner, built with DB_CYCLES=4, REPEAT_DELAY=8
// and REPEAT_PERIOD=3. The same checks apply with or without BTN_REPEAT_EN.
//
// A reference model describes each channel by how many consecutive edges
// the synchronized input has disagreed with the accepted level. After
// DB_CYCLES+1 such edges, the level flips. For auto-repeat, the model
// counts time since the channel last settled into the held state.
//
// Every cycle, the DUT outputs are compared with the model. Directed steps
// additionally check the fixed edge numbers of the reference scenarios.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  int vectors    = 0;
  int miscompares = 0;
  int edge_n     = 0;

  // Reference model state
  logic [NB-1:0] m_s1, m_s2;
  logic [NB-1:0] exp_level, exp_press, exp_release;
  int            m_run [NB];
  int            m_held [NB];

  button_conditioner #(
    .NUM_BTN      (NB),
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at edge %0d (got timeout, want finish)", edge_n);
    $fatal(1, "[TB] watchdog");
  end

  // Advance the model by one rising edge, using the inputs seen at that edge
  task automatic modelStep(input logic [NB-1:0] raw, input logic rst);
    exp_press   = '0;
    exp_release = '0;
    if (!rst) begin
      m_s1      = '0;
      m_s2      = '0;
      exp_level = '0;
      for (int c = 0; c < NB; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      for (int c = 0; c < NB; c++) begin
        if (m_s2[c] != exp_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            exp_level[c] = ~exp_level[c];
            m_run[c]     = 0;
            m_held[c]    = 0;
            if (exp_level[c]) exp_press[c] = 1'b1;
            else              exp_release[c] = 1'b1;
          end
        end else begin
          if (exp_level[c] && m_run[c] > 0) begin
            m_held[c] = 0;
          end else if (exp_level[c]) begin
            m_held[c]++;
`ifdef BTN_REPEAT_EN
            if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
              exp_press[c] = 1'b1;
`endif
          end
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  // Compare all DUT outputs against the model
  task automatic checkOutput();
    vectors++;
    assert ({btn_level, btn_press, btn_release} === {exp_level, exp_press, exp_release})
    else begin
      miscompares++;
      $error("[TB] FAIL model edge=%0d got lvl/prs/rel=%b/%b/%b want %b/%b/%b",
             edge_n, btn_level, btn_press, btn_release, exp_level, exp_press, exp_release);
    end
  endtask

  // Directed comparison against a value fixed by the scenario
  task automatic checkExpect(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("[TB] FAIL %s edge=%0d got %b want %b", tag, edge_n, got, want);
    end
  endtask

  // Drive inputs away from the active edge, step the model, then check
  task automatic applyStimulus(input logic [NB-1:0] raw, input logic rst);
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    edge_n++;
    modelStep(raw, rst);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [NB-1:0] r_raw;
    logic          r_rst;
    int            hold [NB];

    btn_raw = '0;
    reset   = 1'b0;
    m_s1 = '0; m_s2 = '0;
    exp_level = '0; exp_press = '0; exp_release = '0;
    for (int c = 0; c < NB; c++) begin
      m_run[c] = 0;
      m_held[c] = 0;
    end

    // Reset with both buttons held, then release reset at edge 0
    $display("[TB] scenario: reset with buttons held");
    repeat (3) applyStimulus(2'b11, 1'b0);
    checkExpect("rst_level", btn_level, 2'b00);
    checkExpect("rst_press", btn_press, 2'b00);
    checkExpect("rst_release", btn_release, 2'b00);
    edge_n = -1;
    while (edge_n < 8) begin
      applyStimulus(2'b11, 1'b1);
      if (edge_n == 5) checkExpect("held_press_early", btn_press, 2'b00);
      if (edge_n == 6) begin
        checkExpect("held_press_e6", btn_press, 2'b11);
        checkExpect("held_level_e6", btn_level, 2'b11);
      end
      if (edge_n == 7) begin
        checkExpect("held_press_e7", btn_press, 2'b00);
        checkExpect("held_level_e7", btn_level, 2'b11);
      end
    end

    // Clean press on channel 0 from edge 10, release from edge 40
    $display("[TB] scenario: clean press and release");
    repeat (2) applyStimulus(2'b00, 1'b0);
    edge_n = -1;
    while (edge_n < 55) begin
      if (edge_n >= 9 && edge_n < 39) applyStimulus(2'b01, 1'b1);
      else                            applyStimulus(2'b00, 1'b1);
      if (edge_n == 15) checkExpect("press_e15", btn_press, 2'b00);
      if (edge_n == 16) begin
        checkExpect("press_e16", btn_press, 2'b01);
        checkExpect("level_e16", btn_level, 2'b01);
      end
      if (edge_n == 17) checkExpect("press_e17", btn_press, 2'b00);
`ifdef BTN_REPEAT_EN
      if (edge_n == 24 || edge_n == 27 || edge_n == 30) checkExpect("repeat", btn_press, 2'b01);
      if (edge_n == 25) checkExpect("repeat_gap", btn_press, 2'b00);
`else
      if (edge_n == 24) checkExpect("no_repeat", btn_press, 2'b00);
`endif
      if (edge_n == 45) checkExpect("release_e45", btn_release, 2'b00);
      if (edge_n == 46) begin
        checkExpect("release_e46", btn_release, 2'b01);
        checkExpect("rlevel_e46", btn_level, 2'b00);
      end
      if (edge_n == 47) checkExpect("release_e47", btn_release, 2'b00);
    end

    // Bounce on channel 1: 3-cycle phases never reach the debounce length
    $display("[TB] scenario: bounce rejection");
    repeat (2) applyStimulus(2'b00, 1'b0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(((i / 3) % 2 == 0) ? 2'b10 : 2'b00, 1'b1);
      checkExpect("bounce_ch1", {btn_level[1], btn_press[1]}, {1'b0, btn_release[1]});
    end
    repeat (8) applyStimulus(2'b00, 1'b1);

    // Reset in the middle of a debounce
    $display("[TB] scenario: reset mid-debounce");
    repeat (2) applyStimulus(2'b00, 1'b0);
    edge_n = -1;
    while (edge_n < 24) begin
      if (edge_n < 9)        applyStimulus(2'b00, 1'b1);
      else if (edge_n == 12) applyStimulus(2'b01, 1'b0);
      else                   applyStimulus(2'b01, 1'b1);
      if (edge_n >= 14 && edge_n < 20) checkExpect("mid_rst_quiet", btn_press, 2'b00);
      if (edge_n == 20) checkExpect("mid_rst_press", btn_press, 2'b01);
    end

    // Random hold times per channel, with an occasional reset
    $display("[TB] scenario: randomized");
    r_raw = '0;
    for (int c = 0; c < NB; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold[c] == 0) begin
          r_raw[c] = 1'($urandom_range(0, 1));
          hold[c]  = int'($urandom_range(1, 14));
        end
        hold[c]--;
      end
      r_rst = ($urandom_range(0, 299) != 0);
      applyStimulus(r_raw, r_rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
